// File: rtl/fpg8_cu_pkg.sv
// Shared definitions for the FPG8 control unit: opcodes, state encoding,
// timeout limit and the internal strobe bundle.
package fpg8_cu_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_LD   = 4'd4;
  localparam logic [3:0] OP_ST   = 4'd5;
  localparam logic [3:0] OP_BR   = 4'd6;
  localparam logic [3:0] OP_HALT = 4'd7;

  localparam int unsigned CU_TIMEOUT_LIMIT = 15;
  localparam int unsigned CU_CNT_W         = 4;

  typedef enum logic [4:0] {
    StFetch0 = 5'd0,
    StFetch1 = 5'd1,
    StFetch2 = 5'd2,
    StDecode = 5'd3,
    StExa0   = 5'd4,
    StExa1   = 5'd5,
    StExa2   = 5'd6,
    StLd0    = 5'd7,
    StLd1    = 5'd8,
    StLd2    = 5'd9,
    StSt0    = 5'd10,
    StSt1    = 5'd11,
    StSt2    = 5'd12,
    StBr0    = 5'd13,
    StHalt   = 5'd14,
    StFault  = 5'd15
  } cu_state_e;

  typedef struct packed {
    logic pc_out;
    logic pc_in;
    logic pc_inc;
    logic mar_in;
    logic mdr_in;
    logic mdr_out;
    logic ir_in;
    logic ir_offset_out;
    logic rf_rs1_out;
    logic rf_rs2_out;
    logic rf_rd_in;
    logic a_in;
    logic z_in;
    logic z_out;
    logic mem_rd;
    logic mem_wr;
    logic [1:0] alu_op;
    logic halted;
    logic fault;
  } cu_ctrl_t;

  // States that stall on mem_ready and are subject to the timeout.
  function automatic logic is_wait_state(cu_state_e st);
    return (st == StFetch1) || (st == StLd1) || (st == StSt2);
  endfunction

endpackage

// File: rtl/cu_wait_timer.sv
// Memory wait counter: counts not-ready cycles while in a wait state and
// clears whenever the FSM is outside one (i.e. on every fresh entry).
module cu_wait_timer
  import fpg8_cu_pkg::*;
(
  input  logic clk_i,
  input  logic reset_i,
  input  logic wait_i,
  input  logic ready_i,
  output logic expired_o
);

  localparam logic [CU_CNT_W-1:0] Limit = CU_CNT_W'(CU_TIMEOUT_LIMIT);

  logic [CU_CNT_W-1:0] count_q, count_d;

  // Next count: clear outside wait states, saturate at the limit.
  always_comb begin
    count_d = count_q;
    if (!wait_i) begin
      count_d = '0;
    end else if (!ready_i && (count_q != Limit)) begin
      count_d = count_q + CU_CNT_W'(1);
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = wait_i && (count_q == Limit);

endmodule

// File: rtl/control_unit.sv
// FPG8 hardwired Moore control unit. Define CU_MEM_TIMEOUT_EN to add the
// memory wait timeout and the sticky FAULT state; otherwise waits are unbounded.
module control_unit
  import fpg8_cu_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] opcode,
  input  logic       S,
  input  logic       z_flag,
  input  logic       mem_ready,
  output logic       PC_out,
  output logic       PC_in,
  output logic       PC_inc,
  output logic       MAR_in,
  output logic       MDR_in,
  output logic       MDR_out,
  output logic       IR_in,
  output logic       IR_offset_out,
  output logic       RF_rs1_out,
  output logic       RF_rs2_out,
  output logic       RF_rd_in,
  output logic       A_in,
  output logic       Z_in,
  output logic       Z_out,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic [1:0] ALU_op,
  output logic       halted,
  output logic       fault,
  output logic [4:0] state_out
);

  cu_state_e state_q, state_d;
  // ALU function captured in DECODE so later opcode changes are ignored.
  logic [1:0] alu_op_q, alu_op_d;
  cu_ctrl_t   ctrl, ctrl_out;
  logic       timeout;

`ifdef CU_MEM_TIMEOUT_EN
  logic tmo_expired;

  cu_wait_timer u_wait_timer (
    .clk_i     (clk),
    .reset_i   (reset),
    .wait_i    (is_wait_state(state_q)),
    .ready_i   (mem_ready),
    .expired_o (tmo_expired)
  );

  assign timeout = tmo_expired;
`else
  assign timeout = 1'b0;
`endif

  // Next-state and Moore output decode; ready always beats timeout.
  always_comb begin
    state_d  = state_q;
    alu_op_d = alu_op_q;
    ctrl     = '0;
    unique case (state_q)
      StFetch0: begin
        ctrl.pc_out = 1'b1;
        ctrl.mar_in = 1'b1;
        state_d     = StFetch1;
      end
      StFetch1: begin
        ctrl.mem_rd = 1'b1;
        ctrl.mdr_in = mem_ready;
        if (mem_ready)    state_d = StFetch2;
        else if (timeout) state_d = StFault;
      end
      StFetch2: begin
        ctrl.mdr_out = 1'b1;
        ctrl.ir_in   = 1'b1;
        ctrl.pc_inc  = 1'b1;
        state_d      = StDecode;
      end
      StDecode: begin
        alu_op_d = opcode[1:0];
        if (opcode[3]) begin
          state_d = StFetch0;
        end else begin
          unique case (opcode[2:0])
            3'd0, 3'd1, 3'd2, 3'd3: state_d = StExa0;
            3'd4:    state_d = StLd0;
            3'd5:    state_d = StSt0;
            3'd6:    state_d = (!S || z_flag) ? StBr0 : StFetch0;
            default: state_d = StHalt;
          endcase
        end
      end
      StExa0: begin
        ctrl.rf_rs1_out = 1'b1;
        ctrl.a_in       = 1'b1;
        state_d         = StExa1;
      end
      StExa1: begin
        ctrl.rf_rs2_out = 1'b1;
        ctrl.z_in       = 1'b1;
        ctrl.alu_op     = alu_op_q;
        state_d         = StExa2;
      end
      StExa2: begin
        ctrl.z_out    = 1'b1;
        ctrl.rf_rd_in = 1'b1;
        state_d       = StFetch0;
      end
      StLd0: begin
        ctrl.rf_rs1_out = 1'b1;
        ctrl.mar_in     = 1'b1;
        state_d         = StLd1;
      end
      StLd1: begin
        ctrl.mem_rd = 1'b1;
        ctrl.mdr_in = mem_ready;
        if (mem_ready)    state_d = StLd2;
        else if (timeout) state_d = StFault;
      end
      StLd2: begin
        ctrl.mdr_out  = 1'b1;
        ctrl.rf_rd_in = 1'b1;
        state_d       = StFetch0;
      end
      StSt0: begin
        ctrl.rf_rs1_out = 1'b1;
        ctrl.mar_in     = 1'b1;
        state_d         = StSt1;
      end
      StSt1: begin
        ctrl.rf_rs2_out = 1'b1;
        ctrl.mdr_in     = 1'b1;
        state_d         = StSt2;
      end
      StSt2: begin
        ctrl.mem_wr = 1'b1;
        if (mem_ready)    state_d = StFetch0;
        else if (timeout) state_d = StFault;
      end
      StBr0: begin
        ctrl.ir_offset_out = 1'b1;
        ctrl.pc_in         = 1'b1;
        state_d            = StFetch0;
      end
      StHalt: begin
        ctrl.halted = 1'b1;
      end
      StFault: begin
`ifdef CU_MEM_TIMEOUT_EN
        ctrl.fault = 1'b1;
`else
        state_d = StFetch0;
`endif
      end
      default: state_d = StFetch0;
    endcase
  end

  // State and captured ALU function, synchronous reset to FETCH0.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StFetch0;
      alu_op_q <= '0;
    end else begin
      state_q  <= state_d;
      alu_op_q <= alu_op_d;
    end
  end

  // Outputs are forced quiet for the whole reset cycle.
  assign ctrl_out = reset ? '0 : ctrl;

  assign PC_out        = ctrl_out.pc_out;
  assign PC_in         = ctrl_out.pc_in;
  assign PC_inc        = ctrl_out.pc_inc;
  assign MAR_in        = ctrl_out.mar_in;
  assign MDR_in        = ctrl_out.mdr_in;
  assign MDR_out       = ctrl_out.mdr_out;
  assign IR_in         = ctrl_out.ir_in;
  assign IR_offset_out = ctrl_out.ir_offset_out;
  assign RF_rs1_out    = ctrl_out.rf_rs1_out;
  assign RF_rs2_out    = ctrl_out.rf_rs2_out;
  assign RF_rd_in      = ctrl_out.rf_rd_in;
  assign A_in          = ctrl_out.a_in;
  assign Z_in          = ctrl_out.z_in;
  assign Z_out         = ctrl_out.z_out;
  assign mem_rd        = ctrl_out.mem_rd;
  assign mem_wr        = ctrl_out.mem_wr;
  assign ALU_op        = ctrl_out.alu_op;
  assign halted        = ctrl_out.halted;
  assign fault         = ctrl_out.fault;
  assign state_out     = state_q;

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: latency table, directed corner
// sequences and a randomized run against a micro-step queue model.
module tb_control_unit;
  import fpg8_cu_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic [3:0] opcode;
  logic S, z_flag, mem_ready;
  logic PC_out, PC_in, PC_inc, MAR_in, MDR_in, MDR_out, IR_in, IR_offset_out;
  logic RF_rs1_out, RF_rs2_out, RF_rd_in, A_in, Z_in, Z_out, mem_rd, mem_wr;
  logic [1:0] ALU_op;
  logic halted, fault;
  logic [4:0] state_out;

  always #5 clk = ~clk;

  control_unit dut (
    .clk(clk), .reset(reset), .opcode(opcode), .S(S), .z_flag(z_flag),
    .mem_ready(mem_ready), .PC_out(PC_out), .PC_in(PC_in), .PC_inc(PC_inc),
    .MAR_in(MAR_in), .MDR_in(MDR_in), .MDR_out(MDR_out), .IR_in(IR_in),
    .IR_offset_out(IR_offset_out), .RF_rs1_out(RF_rs1_out), .RF_rs2_out(RF_rs2_out),
    .RF_rd_in(RF_rd_in), .A_in(A_in), .Z_in(Z_in), .Z_out(Z_out), .mem_rd(mem_rd),
    .mem_wr(mem_wr), .ALU_op(ALU_op), .halted(halted), .fault(fault),
    .state_out(state_out)
  );

  // Strobe bit positions in the bench's packed view.
  localparam logic [15:0] B_PC_OUT = 16'h8000, B_PC_IN  = 16'h4000, B_PC_INC = 16'h2000;
  localparam logic [15:0] B_MAR_IN = 16'h1000, B_MDR_IN = 16'h0800, B_MDR_OUT = 16'h0400;
  localparam logic [15:0] B_IR_IN  = 16'h0200, B_IROFF  = 16'h0100, B_RS1 = 16'h0080;
  localparam logic [15:0] B_RS2    = 16'h0040, B_RD_IN  = 16'h0020, B_A_IN = 16'h0010;
  localparam logic [15:0] B_Z_IN   = 16'h0008, B_Z_OUT  = 16'h0004, B_MEM_RD = 16'h0002;
  localparam logic [15:0] B_MEM_WR = 16'h0001;
  localparam logic [15:0] BUS_MASK = B_PC_OUT | B_MDR_OUT | B_IROFF | B_RS1 | B_RS2 | B_Z_OUT;

  // One expected cycle of an instruction's microprogram.
  typedef struct {
    cu_state_e   st;
    logic [15:0] strb;
    logic [1:0]  aop;
    bit          wt;
    bit          mdrq;
    bit          dec;
    bit          hlt;
    bit          flt;
  } step_t;

  typedef struct {
    logic [3:0] op;
    logic       s;
    logic       z;
    int         lat;
  } vec_t;

  step_t q[$];
  int    wait_cnt;
  int    checks = 0;
  int    failures = 0;

  function automatic logic [15:0] strobes();
    return {PC_out, PC_in, PC_inc, MAR_in, MDR_in, MDR_out, IR_in, IR_offset_out,
            RF_rs1_out, RF_rs2_out, RF_rd_in, A_in, Z_in, Z_out, mem_rd, mem_wr};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic step_t mk(cu_state_e st, logic [15:0] strb, logic [1:0] aop = 2'd0,
                               bit wt = 0, bit mdrq = 0, bit dec = 0, bit hlt = 0,
                               bit flt = 0);
    step_t s;
    s.st = st; s.strb = strb; s.aop = aop; s.wt = wt; s.mdrq = mdrq;
    s.dec = dec; s.hlt = hlt; s.flt = flt;
    return s;
  endfunction

  task automatic push_fetch();
    q.push_back(mk(StFetch0, B_PC_OUT | B_MAR_IN));
    q.push_back(mk(StFetch1, B_MEM_RD, 2'd0, 1, 1));
    q.push_back(mk(StFetch2, B_MDR_OUT | B_IR_IN | B_PC_INC));
    q.push_back(mk(StDecode, 16'h0, 2'd0, 0, 0, 1));
  endtask

  // Execute phase of an instruction, chosen from the operands seen in DECODE.
  task automatic push_tail(input logic [3:0] op, input logic s, input logic z);
    int unsigned o = op;
    if (o <= 3) begin
      q.push_back(mk(StExa0, B_RS1 | B_A_IN));
      q.push_back(mk(StExa1, B_RS2 | B_Z_IN, op[1:0]));
      q.push_back(mk(StExa2, B_Z_OUT | B_RD_IN));
    end else if (o == 4) begin
      q.push_back(mk(StLd0, B_RS1 | B_MAR_IN));
      q.push_back(mk(StLd1, B_MEM_RD, 2'd0, 1, 1));
      q.push_back(mk(StLd2, B_MDR_OUT | B_RD_IN));
    end else if (o == 5) begin
      q.push_back(mk(StSt0, B_RS1 | B_MAR_IN));
      q.push_back(mk(StSt1, B_RS2 | B_MDR_IN));
      q.push_back(mk(StSt2, B_MEM_WR, 2'd0, 1, 0));
    end else if (o == 6) begin
      if (!s || z) q.push_back(mk(StBr0, B_IROFF | B_PC_IN));
    end else if (o == 7) begin
      q.push_back(mk(StHalt, 16'h0, 2'd0, 0, 0, 0, 1));
    end
  endtask

  // Drive one cycle of inputs, check every output against the model, advance it.
  task automatic cycle(input logic [3:0] op, input logic s, input logic z,
                       input logic rdy, input logic rst);
    step_t e;
    logic [15:0] exp_strb;
    @(negedge clk);
    opcode = op; S = s; z_flag = z; mem_ready = rdy; reset = rst;
    #1;
    chk("bus_single_driver", 32'($countones(strobes() & BUS_MASK) <= 1), 32'd1);
    if (rst) begin
      chk("reset_strobes", strobes(), 0);
      chk("reset_alu_op", ALU_op, 0);
      chk("reset_halted", halted, 0);
      chk("reset_fault", fault, 0);
      q.delete();
      wait_cnt = 0;
      return;
    end
    if (q.size() == 0) push_fetch();
    e = q[0];
    exp_strb = e.strb | ((e.mdrq && rdy) ? B_MDR_IN : 16'h0);
    chk("state_out", state_out, e.st);
    chk("strobes", strobes(), exp_strb);
    chk("alu_op", ALU_op, e.aop);
    chk("halted", halted, e.hlt);
    chk("fault", fault, e.flt);
    if (e.hlt || e.flt) return;
    if (e.wt && !rdy) begin
`ifdef CU_MEM_TIMEOUT_EN
      if (wait_cnt == CU_TIMEOUT_LIMIT) begin
        q.delete();
        q.push_back(mk(StFault, 16'h0, 2'd0, 0, 0, 0, 0, 1));
      end else begin
        wait_cnt++;
      end
`endif
      return;
    end
    void'(q.pop_front());
    wait_cnt = 0;
    if (e.dec) push_tail(op, s, z);
  endtask

  task automatic do_reset();
    cycle(4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'b1);
  endtask

  initial begin
    vec_t tbl[10];
    int lat, cnt;
    tbl[0] = '{4'd0, 1'b0, 1'b0, 7};  tbl[1] = '{4'd1, 1'b1, 1'b1, 7};
    tbl[2] = '{4'd2, 1'b0, 1'b1, 7};  tbl[3] = '{4'd3, 1'b1, 1'b0, 7};
    tbl[4] = '{4'd4, 1'b0, 1'b0, 7};  tbl[5] = '{4'd5, 1'b1, 1'b1, 7};
    tbl[6] = '{4'd6, 1'b0, 1'b0, 5};  tbl[7] = '{4'd6, 1'b1, 1'b0, 4};
    tbl[8] = '{4'd6, 1'b1, 1'b1, 5};  tbl[9] = '{4'd12, 1'b0, 1'b1, 4};
    reset = 1'b1; opcode = '0; S = 1'b0; z_flag = 1'b0; mem_ready = 1'b0;
    do_reset();

    // Instruction latencies with memory always ready.
    foreach (tbl[i]) begin
      do_reset();
      lat = -1;
      for (int n = 1; n <= 12; n++) begin
        cycle(tbl[i].op, tbl[i].s, tbl[i].z, 1'b1, 1'b0);
        if (n > 1 && state_out == StFetch0) begin
          lat = n - 1;
          break;
        end
      end
      chk($sformatf("latency_op%0d_s%0d_z%0d", tbl[i].op, tbl[i].s, tbl[i].z), lat,
          tbl[i].lat);
    end

    // Store with three not-ready cycles in ST2: mem_wr spans four cycles.
    do_reset();
    for (int n = 0; n < 6; n++) cycle(OP_ST, 1'b0, 1'b0, 1'b1, 1'b0);
    cnt = 0;
    for (int n = 0; n < 4; n++) begin
      cycle(OP_ST, 1'b0, 1'b0, n == 3, 1'b0);
      cnt += int'(mem_wr);
    end
    chk("store_mem_wr_cycles", cnt, 4);
    cycle(OP_ADD, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("store_back_to_fetch0", state_out, StFetch0);

    // ALU op captured in DECODE: opcode changes afterwards are ignored.
    do_reset();
    for (int n = 0; n < 4; n++) cycle(OP_AND, 1'b0, 1'b0, 1'b1, 1'b0);
    cycle(OP_OR, 1'b1, 1'b1, 1'b1, 1'b0);
    cycle(OP_SUB, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("alu_op_captured", ALU_op, 2'd2);

    // Halt holds indefinitely, reset releases it.
    do_reset();
    for (int n = 0; n < 4; n++) cycle(OP_HALT, 1'b0, 1'b0, 1'b1, 1'b0);
    cnt = 0;
    for (int n = 0; n < 20; n++) begin
      cycle(4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'b0);
      cnt += int'(halted);
    end
    chk("halt_cycles", cnt, 20);
    do_reset();
    cycle(OP_ADD, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("halt_released_state", state_out, StFetch0);
    chk("halt_released_flag", halted, 0);

`ifdef CU_MEM_TIMEOUT_EN
    // Sixteen not-ready cycles in FETCH1 (count reaches the limit) -> FAULT.
    do_reset();
    cycle(OP_ADD, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int n = 0; n < 16; n++) cycle(OP_ADD, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(OP_ADD, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("timeout_fault_state", state_out, StFault);
    chk("timeout_fault_flag", fault, 1);
    for (int n = 0; n < 5; n++) cycle(OP_ADD, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("fault_sticky", fault, 1);
    // Ready arriving on the cycle the count reaches the limit wins.
    do_reset();
    cycle(OP_ADD, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int n = 0; n < 15; n++) cycle(OP_ADD, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(OP_ADD, 1'b0, 1'b0, 1'b1, 1'b0);
    cycle(OP_ADD, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("ready_at_limit_state", state_out, StFetch2);
    chk("ready_at_limit_fault", fault, 0);
`endif

    // Randomized run; occasional resets, more likely when stuck in HALT/FAULT.
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      logic rst;
      rst = ($urandom_range(0, 99) == 0) ||
            (q.size() != 0 && (q[0].hlt || q[0].flt) && $urandom_range(0, 7) == 0);
      cycle(4'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 3) != 0, rst);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
